jump_judge_ras: RTL and testbench

Parametrised D-stage jump resolver for the dual-issue MIPS pipeline. It detects `j/jal/jr/jalr`, computes the jump target and checks register dependences of `jr/jalr` against `ISSUE_W` lanes of E and M writers. It adds a return-address stack (RAS) so that a dependent `jr $31` is taken speculatively instead of stalling. The block holds one outstanding prediction and checks it when the true `rs` value arrives in E.

---
 rtl/jump_judge_ras.sv | 157 +++++++++++++++
 tb/tb_jump_judge_ras.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_judge_ras.sv
// D-stage jump resolver with an optional return-address stack.
// Define JUMP_RAS_EN to speculate dependent `jr $31` from the RAS.
module jump_judge_ras #(
  parameter int ISSUE_W   = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enaD,
  input  logic                   flushD,
  input  logic [31:0]            instrD,
  input  logic [31:0]            pc_plus4D,
  input  logic [31:0]            rs_valueD,
  input  logic [2*ISSUE_W-1:0]   fwd_wen,
  input  logic [10*ISSUE_W-1:0]  fwd_waddr,
  input  logic                   resolve_validE,
  input  logic [31:0]            resolve_targetE,
  output logic                   is_jumpD,
  output logic                   jump_takeD,
  output logic                   jump_conflictD,
  output logic [31:0]            jump_targetD,
  output logic                   ras_predD,
  output logic                   mispredictE,
  output logic [31:0]            redirect_targetE
);
  localparam int NW = 2 * ISSUE_W;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic        is_j;
  logic        is_jr;
  logic        is_call;
  logic        is_ret;
  logic        dep;
  logic        pred;
  logic [31:0] ras_top;

  assign op      = instrD[31:26];
  assign fn      = instrD[5:0];
  assign rs      = instrD[25:21];
  assign is_jr   = (op == 6'd0) && (fn[5:1] == 5'b00100);
  assign is_j    = (op[5:1] == 5'b00001);
  assign is_call = (op == 6'b000011) ||
                   ((op == 6'd0) && (fn == 6'b001001));
  assign is_ret  = is_jr && (fn == 6'b001000) && (rs == 5'd31);

  always_comb begin
    dep = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (fwd_wen[k] && (fwd_waddr[5*k +: 5] == rs) && (rs != 5'd0))
        dep = 1'b1;
    end
    dep = dep & is_jr;
  end

  assign is_jumpD       = is_j | is_jr;
  assign jump_conflictD = dep & ~pred;
  assign jump_takeD     = enaD & (is_j | (is_jr & ~jump_conflictD));
  assign ras_predD      = pred;

  always_comb begin
    jump_targetD = '0;
    if (pred)
      jump_targetD = ras_top;
    else if (is_j)
      jump_targetD = {pc_plus4D[31:28], instrD[25:0], 2'b00};
    else if (is_jr)
      jump_targetD = rs_valueD;
  end

`ifdef JUMP_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [31:0]   ras_q [RAS_DEPTH];
  logic [31:0]   ras_d [RAS_DEPTH];
  logic [PW-1:0] tos_q, tos_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_v_q, pend_v_d;
  logic [31:0]   pend_tgt_q, pend_tgt_d;
  logic [31:0]   ret_addr;
  logic          upd;
  logic          mis;

  assign ret_addr         = pc_plus4D + 32'd4;
  assign ras_top          = ras_q[tos_q];
  assign upd              = enaD & ~flushD;
  assign pred             = is_ret & dep & (count_q != '0) & ~pend_v_q;
  assign mis              = resolve_validE & pend_v_q &
                            (resolve_targetE != pend_tgt_q);
  assign mispredictE      = mis;
  assign redirect_targetE = resolve_targetE;

  always_comb begin
    ras_d      = ras_q;
    tos_d      = tos_q;
    count_d    = count_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    if (resolve_validE & pend_v_q)
      pend_v_d = 1'b0;
    if (upd) begin
      if (is_call) begin
        // jalr $31 swaps the top entry in place
        if (is_jr && (rs == 5'd31) && (count_q != '0)) begin
          ras_d[tos_q] = ret_addr;
        end else begin
          tos_d        = tos_q + PW'(1);
          ras_d[tos_d] = ret_addr;
          if (count_q != FULL)
            count_d = count_q + CW'(1);
        end
      end else if (is_ret && jump_takeD && (count_q != '0)) begin
        tos_d   = tos_q - PW'(1);
        count_d = count_q - CW'(1);
      end
      if (pred) begin
        pend_v_d   = 1'b1;
        pend_tgt_d = ras_q[tos_q];
      end
    end
    if (mis) begin
      ras_d   = ras_q;
      tos_d   = tos_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_q[i] <= '0;
      tos_q      <= '0;
      count_q    <= '0;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      ras_q      <= ras_d;
      tos_q      <= tos_d;
      count_q    <= count_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
`else
  logic unused_sig;

  assign pred             = 1'b0;
  assign ras_top          = '0;
  assign mispredictE      = 1'b0;
  assign redirect_targetE = '0;
  assign unused_sig = ^{clk, rst, resolve_validE, resolve_targetE,
                        is_call, is_ret};
`endif
endmodule

// File: tb/tb_jump_judge_ras.sv
// Directed bench for jump_judge_ras, covering both RAS build options.
module tb_jump_judge_ras;
  localparam int IW = 2;
  localparam int RD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enaD, flushD;
  logic [31:0]   instrD, pc_plus4D, rs_valueD;
  logic [2*IW-1:0]  fwd_wen;
  logic [10*IW-1:0] fwd_waddr;
  logic          resolve_validE;
  logic [31:0]   resolve_targetE;
  logic          is_jumpD, jump_takeD, jump_conflictD;
  logic [31:0]   jump_targetD;
  logic          ras_predD, mispredictE;
  logic [31:0]   redirect_targetE;

  int n_cmp = 0;
  int n_bad = 0;

  jump_judge_ras #(.ISSUE_W(IW), .RAS_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .enaD(enaD), .flushD(flushD),
    .instrD(instrD), .pc_plus4D(pc_plus4D), .rs_valueD(rs_valueD),
    .fwd_wen(fwd_wen), .fwd_waddr(fwd_waddr),
    .resolve_validE(resolve_validE), .resolve_targetE(resolve_targetE),
    .is_jumpD(is_jumpD), .jump_takeD(jump_takeD),
    .jump_conflictD(jump_conflictD), .jump_targetD(jump_targetD),
    .ras_predD(ras_predD), .mispredictE(mispredictE),
    .redirect_targetE(redirect_targetE)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] JAL = 32'h0C00_0000;

  function automatic logic [31:0] enc_jr(input logic [4:0] r);
    return {6'd0, r, 15'd0, 6'b001000};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] r);
    return {6'd0, r, 5'd0, 5'd31, 5'd0, 6'b001001};
  endfunction

  task automatic idle();
    instrD = '0; enaD = 1'b1; flushD = 1'b0;
    pc_plus4D = '0; rs_valueD = '0;
    fwd_wen = '0; fwd_waddr = '0;
    resolve_validE = 1'b0; resolve_targetE = '0;
  endtask

  task automatic set_fwd(input int k, input logic [4:0] a);
    fwd_wen[k] = 1'b1;
    fwd_waddr[5*k +: 5] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  // dependent return on M writer lane 0 (writer index 2)
  task automatic dep_ret(input logic en);
    instrD = enc_jr(5'd31); enaD = en; set_fwd(2, 5'd31);
  endtask

  task automatic push(input logic [31:0] pc4);
    instrD = JAL; pc_plus4D = pc4;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    pc_plus4D = 32'h1234; rs_valueD = 32'hdead;
    #1;
    n_cmp++;
    if ({is_jumpD, jump_takeD, jump_conflictD, ras_predD, mispredictE} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 00000",
        {is_jumpD, jump_takeD, jump_conflictD, ras_predD, mispredictE});
    end
    n_cmp++;
    if (jump_targetD !== 32'h0 || redirect_targetE !== 32'h0) begin
      n_bad++; $display("FAIL reset_targets got %h/%h want 0/0", jump_targetD, redirect_targetE);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_j();
    instrD = 32'h0800_0010; pc_plus4D = 32'h4000_0004;
    #1;
    n_cmp++;
    if ({is_jumpD, jump_takeD, jump_conflictD} !== 3'b110) begin
      n_bad++; $display("FAIL j_flags got %b want 110", {is_jumpD, jump_takeD, jump_conflictD});
    end
    n_cmp++;
    if (jump_targetD !== 32'h4000_0040) begin
      n_bad++; $display("FAIL j_target got %h want 40000040", jump_targetD);
    end
    tick();
    dep_ret(1'b0);
    #1;
    n_cmp++;
    if ({jump_conflictD, ras_predD} !== 2'b10) begin
      n_bad++; $display("FAIL j_no_push got %b want 10", {jump_conflictD, ras_predD});
    end
    tick();
  endtask

  task automatic test_conflict();
    instrD = enc_jr(5'd5); set_fwd(1, 5'd5);
    #1;
    n_cmp++;
    if ({jump_conflictD, jump_takeD} !== 2'b10) begin
      n_bad++; $display("FAIL jr5_dep got %b want 10", {jump_conflictD, jump_takeD});
    end
    idle();
    instrD = enc_jr(5'd5); fwd_waddr[9:5] = 5'd5; rs_valueD = 32'h0000_7770;
    #1;
    n_cmp++;
    if ({jump_conflictD, jump_takeD} !== 2'b01 || jump_targetD !== 32'h7770) begin
      n_bad++; $display("FAIL jr5_nowen got %b/%h want 01/00007770",
        {jump_conflictD, jump_takeD}, jump_targetD);
    end
    idle();
    instrD = enc_jr(5'd0); set_fwd(1, 5'd0); rs_valueD = 32'h55;
    #1;
    n_cmp++;
    if ({jump_conflictD, jump_takeD} !== 2'b01 || jump_targetD !== 32'h55) begin
      n_bad++; $display("FAIL jr0_nodep got %b/%h want 01/00000055",
        {jump_conflictD, jump_takeD}, jump_targetD);
    end
    tick();
  endtask

`ifdef JUMP_RAS_EN
  task automatic test_ras_pred();
    push(32'h5004);
    push(32'h1004);
    dep_ret(1'b1); rs_valueD = 32'hbad0;
    #1;
    n_cmp++;
    if ({ras_predD, jump_conflictD, jump_takeD} !== 3'b101 || jump_targetD !== 32'h1008) begin
      n_bad++; $display("FAIL pred_hit got %b/%h want 101/00001008",
        {ras_predD, jump_conflictD, jump_takeD}, jump_targetD);
    end
    tick();
    dep_ret(1'b0);
    #1;
    n_cmp++;
    if ({ras_predD, jump_conflictD} !== 2'b01) begin
      n_bad++; $display("FAIL pend_blocks got %b want 01", {ras_predD, jump_conflictD});
    end
    idle();
    resolve_validE = 1'b1; resolve_targetE = 32'h1008;
    #1;
    n_cmp++;
    if (mispredictE !== 1'b0 || redirect_targetE !== 32'h1008) begin
      n_bad++; $display("FAIL resolve_ok got %b/%h want 0/00001008", mispredictE, redirect_targetE);
    end
    tick();
    dep_ret(1'b0);
    #1;
    n_cmp++;
    if ({ras_predD, jump_conflictD} !== 2'b10 || jump_targetD !== 32'h5008) begin
      n_bad++; $display("FAIL pend_cleared got %b/%h want 10/00005008",
        {ras_predD, jump_conflictD}, jump_targetD);
    end
    enaD = 1'b1;
    tick();
    resolve_validE = 1'b1; resolve_targetE = 32'h5008;
    tick();
  endtask

  task automatic test_mispredict();
    push(32'h3004);
    push(32'h1004);
    dep_ret(1'b1);
    tick();
    resolve_validE = 1'b1; resolve_targetE = 32'h2000;
    instrD = JAL; pc_plus4D = 32'h7004;
    #1;
    n_cmp++;
    if (mispredictE !== 1'b1 || redirect_targetE !== 32'h2000) begin
      n_bad++; $display("FAIL mispredict got %b/%h want 1/00002000", mispredictE, redirect_targetE);
    end
    tick();
    dep_ret(1'b0);
    resolve_validE = 1'b1; resolve_targetE = 32'h2000;
    #1;
    n_cmp++;
    if ({ras_predD, jump_conflictD, mispredictE} !== 3'b010) begin
      n_bad++; $display("FAIL after_mispredict got %b want 010",
        {ras_predD, jump_conflictD, mispredictE});
    end
    tick();
  endtask

  task automatic test_jalr_swap();
    push(32'h4004);
    push(32'h6004);
    instrD = enc_jalr(5'd31); pc_plus4D = 32'h8004; rs_valueD = 32'h9000;
    #1;
    n_cmp++;
    if (jump_takeD !== 1'b1 || jump_targetD !== 32'h9000) begin
      n_bad++; $display("FAIL jalr_take got %b/%h want 1/00009000", jump_takeD, jump_targetD);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      dep_ret(1'b0);
      #1;
      n_cmp++;
      if (ras_predD !== 1'b1 || jump_targetD !== (i == 0 ? 32'h8008 : 32'h4008)) begin
        n_bad++; $display("FAIL jalr_swap%0d got %b/%h want 1/%h", i, ras_predD,
          jump_targetD, (i == 0 ? 32'h8008 : 32'h4008));
      end
      idle();
      instrD = enc_jr(5'd31);
      tick();
    end
    dep_ret(1'b0);
    #1;
    n_cmp++;
    if ({ras_predD, jump_conflictD} !== 2'b01) begin
      n_bad++; $display("FAIL jalr_empty got %b want 01", {ras_predD, jump_conflictD});
    end
    tick();
  endtask

  task automatic test_flush();
    instrD = JAL; pc_plus4D = 32'h1104; flushD = 1'b1;
    tick();
    dep_ret(1'b0);
    #1;
    n_cmp++;
    if ({ras_predD, jump_conflictD} !== 2'b01) begin
      n_bad++; $display("FAIL flush_push got %b want 01", {ras_predD, jump_conflictD});
    end
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= RD + 1; i++)
      push(32'(i) << 8);
    for (int i = RD + 1; i >= 2; i--) begin
      dep_ret(1'b0);
      #1;
      n_cmp++;
      if (ras_predD !== 1'b1 || jump_targetD !== ((32'(i) << 8) + 32'd4)) begin
        n_bad++; $display("FAIL lifo_%0d got %b/%h want 1/%h", i, ras_predD,
          jump_targetD, (32'(i) << 8) + 32'd4);
      end
      idle();
      instrD = enc_jr(5'd31);
      tick();
    end
    dep_ret(1'b0);
    #1;
    n_cmp++;
    if ({ras_predD, jump_conflictD} !== 2'b01) begin
      n_bad++; $display("FAIL oldest_lost got %b want 01", {ras_predD, jump_conflictD});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= RD + 1; i++)
      push(32'(i) << 8);
    dep_ret(1'b1);
    tick();
    push(32'hA000);
    resolve_validE = 1'b1; resolve_targetE = 32'h1234;
    #1;
    n_cmp++;
    if (mispredictE !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_pend got %b want 1", mispredictE);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mispredictE !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_pend got %b want 0", mispredictE);
    end
    #2;
    rst = 1'b0;
    idle();
    dep_ret(1'b0);
    #1;
    n_cmp++;
    if ({ras_predD, jump_conflictD} !== 2'b01) begin
      n_bad++; $display("FAIL reset_ras got %b want 01", {ras_predD, jump_conflictD});
    end
    tick();
  endtask
`else
  task automatic test_no_ras();
    push(32'h1004);
    dep_ret(1'b1);
    #1;
    n_cmp++;
    if ({ras_predD, jump_conflictD, jump_takeD} !== 3'b010) begin
      n_bad++; $display("FAIL noras_dep got %b want 010",
        {ras_predD, jump_conflictD, jump_takeD});
    end
    idle();
    resolve_validE = 1'b1; resolve_targetE = 32'h2000;
    #1;
    n_cmp++;
    if (mispredictE !== 1'b0 || redirect_targetE !== 32'h0) begin
      n_bad++; $display("FAIL noras_resolve got %b/%h want 0/00000000",
        mispredictE, redirect_targetE);
    end
    tick();
    instrD = enc_jalr(5'd31); rs_valueD = 32'h9000;
    #1;
    n_cmp++;
    if (jump_takeD !== 1'b1 || jump_targetD !== 32'h9000) begin
      n_bad++; $display("FAIL noras_jalr got %b/%h want 1/00009000", jump_takeD, jump_targetD);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_j();
    test_conflict();
`ifdef JUMP_RAS_EN
    test_ras_pred();
    test_mispredict();
    test_jalr_swap();
    test_flush();
    test_overflow();
    test_reset_mid();
`else
    test_no_ras();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
